// File: rtl/ams_pwm_gen.sv
// Per-channel PWM / first-order sigma-delta pin driver for the RC-filtered PWM DAC.
// Duty, mode and the dither frame are latched at period boundaries so pin updates stay glitch-free.
module ams_pwm_gen #(
  parameter int DW   = 8,
  parameter int SL   = 16,
  parameter int DIVW = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [DW+SL-1:0]   cfg_i,
  input  logic [DIVW-1:0]    freq_div_i,
  input  logic               mode_i,
  output logic               pwm_o,
  output logic               period_o,
  output logic               frame_o
);

  localparam int              SIW       = (SL > 1) ? $clog2(SL) : 1;
  localparam logic [SIW-1:0]  SIDX_LAST = SIW'(SL - 1);
  localparam logic [DW-1:0]   PH_LAST   = '1;

  logic [DIVW-1:0] div_cnt;
  logic [DIVW-1:0] div_last;
  logic            tick;
  logic            bnd;
  logic [DW-1:0]   ph;
  logic [DW-1:0]   duty_r;
  logic [SL-1:0]   seq_r;
  logic            b_r;
  logic [SIW-1:0]  sidx;
  logic            mode_r;
  logic [DW-1:0]   acc;
  logic [DW:0]     thr;
  logic [DW:0]     sd_sum;
  logic            pwm_nxt;
  logic            frame_load;

  // A divider of 0 behaves as 1; ">=" lets a live decrease of the divider wrap at once.
  assign div_last   = (freq_div_i == '0) ? '0 : (freq_div_i - DIVW'(1));
  assign tick       = (div_cnt >= div_last);
  assign bnd        = tick && (ph == PH_LAST);
  assign frame_load = (sidx == SIDX_LAST);

  // Threshold is one bit wider so duty=max plus a dither bit yields a solid high.
  assign thr    = {1'b0, duty_r} + {{DW{1'b0}}, b_r};
  assign sd_sum = {1'b0, acc} + {1'b0, duty_r};

  always_comb begin
    pwm_nxt = pwm_o;
    if (!mode_r) begin
      pwm_nxt = ({1'b0, ph} < thr);
    end else if (tick) begin
      pwm_nxt = sd_sum[DW];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt <= '0;
      ph      <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      ph      <= ph + DW'(1);
    end else begin
      div_cnt <= div_cnt + DIVW'(1);
    end
  end

  // Boundary latching: duty and mode every period, dither frame every SL periods (MSB first).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      duty_r   <= '0;
      mode_r   <= 1'b0;
      seq_r    <= '0;
      b_r      <= 1'b0;
      sidx     <= SIDX_LAST;
      period_o <= 1'b0;
      frame_o  <= 1'b0;
    end else if (bnd) begin
      duty_r   <= cfg_i[DW+SL-1:SL];
      mode_r   <= mode_i;
      sidx     <= frame_load ? '0 : (sidx + SIW'(1));
      period_o <= 1'b1;
      frame_o  <= frame_load;
      if (frame_load) begin
        seq_r <= cfg_i[SL-1:0];
        b_r   <= cfg_i[SL-1];
      end else begin
        seq_r <= {seq_r[SL-2:0], 1'b0};
        b_r   <= seq_r[SL-2];
      end
    end else begin
      period_o <= 1'b0;
      frame_o  <= 1'b0;
    end
  end

  // The pin uses the pre-boundary registers in the boundary cycle itself.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc   <= '0;
      pwm_o <= 1'b0;
    end else begin
      pwm_o <= pwm_nxt;
      if (bnd && (mode_i != mode_r)) begin
        acc <= '0;
      end else if (mode_r && tick) begin
        acc <= sd_sum[DW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_ams_pwm_gen.sv
// Bench for ams_pwm_gen: per-period high-time, strobe timing and reset behaviour
// compared against a period-level arithmetic model of the PWM / sigma-delta rules.
module tb_ams_pwm_gen;

  logic        clk_i;
  logic        rst_i;
  logic [23:0] cfg_i;
  logic [15:0] freq_div_i;
  logic        mode_i;
  logic        pwm_o;
  logic        period_o;
  logic        frame_o;

  int n_chk;
  int n_err;

  ams_pwm_gen #(.DW(8), .SL(16), .DIVW(16)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cfg_i      (cfg_i),
    .freq_div_i (freq_div_i),
    .mode_i     (mode_i),
    .pwm_o      (pwm_o),
    .period_o   (period_o),
    .frame_o    (frame_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d", n_err, n_chk);
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Configuration in force at boundary b (boundaries numbered from 1 after reset).
  function automatic logic [23:0] cfg_at(input int b, input logic [23:0] c1,
                                         input logic [23:0] c2, input int chg);
    return (b > chg) ? c2 : c1;
  endfunction

  // Expected high clocks in the window following boundary k; -1 means "not checked".
  function automatic int exp_high(input int k, input logic [23:0] c1, input logic [23:0] c2,
                                  input int chg, input int de, input logic md);
    logic [23:0] cb;
    logic [23:0] cf;
    logic [15:0] seq;
    int          duty;
    int          bitv;
    int          fstart;
    cb     = cfg_at(k, c1, c2, chg);
    duty   = int'(cb[23:16]);
    fstart = ((k - 1) / 16) * 16 + 1;
    cf     = cfg_at(fstart, c1, c2, chg);
    seq    = cf[15:0];
    bitv   = int'(seq[15 - ((k - 1) % 16)]);
    if (!md) return (duty + bitv) * de;
    if (k == 1 || k == chg + 1) return -1;
    return duty * de;
  endfunction

  // Reset (asynchronously, between edges), configure, then measure np periods.
  task automatic run_seg(input string name, input logic [23:0] c1, input logic [23:0] c2,
                         input int chg, input int fd, input logic md, input int np);
    int de;
    int n;
    int hi;
    int ppos;
    int pcnt;
    int fcnt;
    int eh;
    de = (fd == 0) ? 1 : fd;
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk({name, ":rst_async"}, int'({pwm_o, period_o, frame_o}), 0);
    cfg_i      = c1;
    freq_div_i = 16'(fd);
    mode_i     = md;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!period_o && n < 256 * de + 16);
    chk({name, ":first_bnd"}, n, 256 * de);
    chk({name, ":first_frame"}, int'(frame_o), 1);
    for (int k = 1; k <= np; k++) begin
      hi = 0; ppos = 0; pcnt = 0; fcnt = 0;
      for (int s = 1; s <= 256 * de; s++) begin
        @(negedge clk_i);
        hi   += int'(pwm_o);
        pcnt += int'(period_o);
        fcnt += int'(frame_o);
        if (period_o && ppos == 0) ppos = s;
        if (k == chg && s == 100) cfg_i = c2;
      end
      chk($sformatf("%s:p%0d_pos", name, k), ppos, 256 * de);
      chk($sformatf("%s:p%0d_cnt", name, k), pcnt, 1);
      chk($sformatf("%s:p%0d_frame", name, k), fcnt, (k % 16 == 0) ? 1 : 0);
      eh = exp_high(k, c1, c2, chg, de, md);
      if (eh >= 0) chk($sformatf("%s:p%0d_high", name, k), hi, eh);
    end
  endtask

  initial begin
    int n;
    logic [23:0] rc;
    n_chk = 0;
    n_err = 0;
    rst_i = 1'b1;
    cfg_i = '0;
    freq_div_i = 16'd1;
    mode_i = 1'b0;
    #1;
    chk("reset_outputs", int'({pwm_o, period_o, frame_o}), 0);

    run_seg("half",     24'h800000, 24'h800000, 1000, 1, 1'b0, 33);
    run_seg("dith1",    24'h400001, 24'h400001, 1000, 1, 1'b0, 17);
    run_seg("dithall",  24'h40FFFF, 24'h40FFFF, 1000, 1, 1'b0, 4);
    run_seg("full",     24'hFFFFFF, 24'hFFFFFF, 1000, 1, 1'b0, 4);
    run_seg("zero",     24'h000000, 24'h000000, 1000, 1, 1'b0, 4);
    run_seg("div4",     24'h800000, 24'h800000, 1000, 4, 1'b0, 3);
    run_seg("div0",     24'h800000, 24'h800000, 1000, 0, 1'b0, 3);
    run_seg("sd25",     24'h400000, 24'h400000, 1000, 1, 1'b1, 4);
    run_seg("cfgchg",   24'h40A5A5, 24'hC03C3C, 5,    1, 1'b0, 18);

    // Live divider decrease: 1000 -> 3 with the prescaler at 500.
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    cfg_i = 24'h800000;
    mode_i = 1'b0;
    freq_div_i = 16'd1000;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (500) @(negedge clk_i);
    freq_div_i = 16'd3;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!period_o && n < 2000);
    chk("div_shrink_bnd", n, 766);

    for (int i = 0; i < 6; i++) begin
      rc = 24'($urandom);
      run_seg($sformatf("rnd%0d", i), rc, rc, 1000, int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), int'($urandom_range(2, 5)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
